regfile_sb: RTL and testbench

Parametrised general-purpose register file for the pipelined core, successor to the 8-bit 32-entry file.
- Adds a per-register pending-write scoreboard with hazard stall output.
- Adds same-cycle write-to-read bypass.
- Adds a sequential post-reset clear engine, so storage maps onto RAM with no async reset.
- Sits between decode (issue/read) and writeback (write).

---
 rtl/regfile_pkg.sv | 14 +
 rtl/regfile_scoreboard.sv | 86 ++++++++
 rtl/regfile_sb.sv | 97 +++++++++
 tb/tb_regfile_sb.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared types and helpers for the scoreboarded register file.
package regfile_pkg;

    typedef enum logic [0:0] {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } state_t;

    // Width needed to count 0..depth inclusive.
    function automatic int count_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Pending-write scoreboard: busy bits, busy count, hazard stall and writeback error pulse.
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter  int DEPTH = 32,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = count_width(DEPTH)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          i_run,
    input  logic          i_w,
    input  logic [AW-1:0] i_waddr,
    input  logic [AW-1:0] i_raddr1,
    input  logic [AW-1:0] i_raddr2,
    input  logic          i_issue_valid,
    input  logic [AW-1:0] i_issue_dst,
    input  logic          i_issue_use2,
    output logic          o_stall,
    output logic          o_wr_err,
    output logic [CW-1:0] o_busy_count
);

    logic [DEPTH-1:0] r_busy;
    logic [DEPTH-1:0] w_busy_next;
    logic [DEPTH-1:0] w_beff;
    logic [CW-1:0]    r_busy_count;
    logic             r_wr_err;

    logic w_wr_live;
    logic w_accept;
    logic w_set_en;
    logic w_clr_en;

    assign w_wr_live = i_run & i_w & (i_waddr != '0);

    // A writeback landing this cycle resolves the hazard on its register.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_beff
            assign w_beff[gi] = r_busy[gi] & ~(i_w && (i_waddr == AW'(gi)));
        end
    endgenerate

    assign o_stall = ~i_run
                   | (i_issue_valid & (w_beff[i_raddr1]
                                       | (i_issue_use2 & w_beff[i_raddr2])
                                       | w_beff[i_issue_dst]));

    assign w_accept = i_run & i_issue_valid & ~o_stall;
    assign w_set_en = w_accept & (i_issue_dst != '0);
    assign w_clr_en = w_wr_live & r_busy[i_waddr];

    // Issue wins over writeback when both target the same register.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_busy_next
            if (gi == 0) begin : g_zero
                assign w_busy_next[gi] = 1'b0;
            end else begin : g_reg
                assign w_busy_next[gi] =
                    (w_set_en && (i_issue_dst == AW'(gi))) ? 1'b1 :
                    (w_clr_en && (i_waddr == AW'(gi)))     ? 1'b0 :
                    r_busy[gi];
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset) begin
            r_busy       <= '0;
            r_busy_count <= '0;
            r_wr_err     <= 1'b0;
        end else begin
            r_busy   <= w_busy_next;
            r_wr_err <= w_wr_live & ~r_busy[i_waddr];
            if (w_set_en && !w_clr_en) begin
                r_busy_count <= r_busy_count + CW'(1);
            end else if (w_clr_en && !w_set_en) begin
                r_busy_count <= r_busy_count - CW'(1);
            end
        end
    end

    assign o_wr_err     = r_wr_err;
    assign o_busy_count = r_busy_count;

endmodule

// File: rtl/regfile_sb.sv
// Register file with post-reset clear engine, write-to-read bypass and pending-write scoreboard.
module regfile_sb
    import regfile_pkg::*;
#(
    parameter  int WIDTH = 8,
    parameter  int DEPTH = 32,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = count_width(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    output logic             ready,
    input  logic [AW-1:0]    Raddr1,
    input  logic [AW-1:0]    Raddr2,
    output logic [WIDTH-1:0] Rdata1,
    output logic [WIDTH-1:0] Rdata2,
    input  logic             w,
    input  logic [AW-1:0]    Waddr,
    input  logic [WIDTH-1:0] Wdata,
    input  logic             issue_valid,
    input  logic [AW-1:0]    issue_dst,
    input  logic             issue_use2,
    output logic             stall,
    output logic             wr_err,
    output logic [CW-1:0]    busy_count
);

    state_t            r_state;
    logic [AW-1:0]     r_clr_ptr;
    logic [WIDTH-1:0]  r_gpr [DEPTH];

    logic              w_ready;
    logic              w_clearing;
    logic              w_we;
    logic [AW-1:0]     w_waddr;
    logic [WIDTH-1:0]  w_wdata;

    assign w_ready    = (r_state == RUN);
    assign w_clearing = (r_state == CLEAR);
    assign ready      = w_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= CLEAR;
            r_clr_ptr <= AW'(1);
        end else if (w_clearing) begin
            r_clr_ptr <= r_clr_ptr + AW'(1);
            if (r_clr_ptr == AW'(DEPTH - 1)) begin
                r_state <= RUN;
            end
        end
    end

    // Single write port shared by the clear engine and writeback keeps storage RAM-mappable.
    assign w_we    = ~reset & (w_clearing | (w && (Waddr != '0)));
    assign w_waddr = w_clearing ? r_clr_ptr : Waddr;
    assign w_wdata = w_clearing ? '0 : Wdata;

    always_ff @(posedge clk) begin
        if (w_we) begin
            r_gpr[w_waddr] <= w_wdata;
        end
    end

    always_comb begin
        Rdata1 = '0;
        if (w_ready && (Raddr1 != '0)) begin
            Rdata1 = (w && (Waddr == Raddr1)) ? Wdata : r_gpr[Raddr1];
        end
    end

    always_comb begin
        Rdata2 = '0;
        if (w_ready && (Raddr2 != '0)) begin
            Rdata2 = (w && (Waddr == Raddr2)) ? Wdata : r_gpr[Raddr2];
        end
    end

    regfile_scoreboard #(
        .DEPTH (DEPTH)
    ) u_scoreboard (
        .clk           (clk),
        .reset         (reset),
        .i_run         (w_ready),
        .i_w           (w),
        .i_waddr       (Waddr),
        .i_raddr1      (Raddr1),
        .i_raddr2      (Raddr2),
        .i_issue_valid (issue_valid),
        .i_issue_dst   (issue_dst),
        .i_issue_use2  (issue_use2),
        .o_stall       (stall),
        .o_wr_err      (wr_err),
        .o_busy_count  (busy_count)
    );

endmodule

// File: tb/tb_regfile_sb.sv
// Directed self-checking bench for regfile_sb (WIDTH=8, DEPTH=32).
module tb_regfile_sb;

    localparam int WIDTH = 8;
    localparam int DEPTH = 32;
    localparam int AW    = 5;
    localparam int CW    = 6;

    logic             clk = 1'b0;
    logic             reset;
    logic             ready;
    logic [AW-1:0]    Raddr1, Raddr2;
    logic [WIDTH-1:0] Rdata1, Rdata2;
    logic             w;
    logic [AW-1:0]    Waddr;
    logic [WIDTH-1:0] Wdata;
    logic             issue_valid;
    logic [AW-1:0]    issue_dst;
    logic             issue_use2;
    logic             stall;
    logic             wr_err;
    logic [CW-1:0]    busy_count;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    regfile_sb #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk         (clk),
        .reset       (reset),
        .ready       (ready),
        .Raddr1      (Raddr1),
        .Raddr2      (Raddr2),
        .Rdata1      (Rdata1),
        .Rdata2      (Rdata2),
        .w           (w),
        .Waddr       (Waddr),
        .Wdata       (Wdata),
        .issue_valid (issue_valid),
        .issue_dst   (issue_dst),
        .issue_use2  (issue_use2),
        .stall       (stall),
        .wr_err      (wr_err),
        .busy_count  (busy_count)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end else begin
            $display("ok   %s: %0h", tag, got);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Expect ready low for DEPTH-2 edges, then high on the DEPTH-1'th edge after reset drops.
    task automatic check_clear_run(input string tag);
        int low_bad;
        low_bad = 0;
        for (int i = 1; i < DEPTH - 1; i++) begin
            tick();
            if (ready !== 1'b0) low_bad++;
        end
        chk({tag, "_ready_low_count"}, 32'(low_bad), 32'd0);
        tick();
        chk({tag, "_ready_high"}, 32'(ready), 32'd1);
    endtask

    task automatic idle_inputs;
        w = 1'b0; Waddr = '0; Wdata = '0;
        issue_valid = 1'b0; issue_dst = '0; issue_use2 = 1'b0;
        Raddr1 = '0; Raddr2 = '0;
    endtask

    initial begin
        int zero_bad;
        reset = 1'b1;
        idle_inputs();
        Raddr1 = 5'd5;
        tick();
        tick();
        chk("rst_ready", 32'(ready), 32'd0);
        chk("rst_wr_err", 32'(wr_err), 32'd0);
        chk("rst_busy_count", 32'(busy_count), 32'd0);
        chk("rst_stall", 32'(stall), 32'd1);
        chk("rst_rdata1", 32'(Rdata1), 32'd0);

        reset = 1'b0;
        check_clear_run("clear1");

        zero_bad = 0;
        for (int a = 0; a < DEPTH; a++) begin
            Raddr1 = AW'(a); Raddr2 = AW'(DEPTH - 1 - a);
            #1;
            if (Rdata1 !== 8'h00 || Rdata2 !== 8'h00) zero_bad++;
        end
        chk("cleared_reads_nonzero", 32'(zero_bad), 32'd0);
        chk("run_stall_idle", 32'(stall), 32'd0);

        // Bypass
        w = 1'b1; Waddr = 5'd5; Wdata = 8'hA5; Raddr1 = 5'd5; Raddr2 = 5'd6;
        #1;
        chk("bypass_rdata1", 32'(Rdata1), 32'hA5);
        chk("bypass_rdata2_other", 32'(Rdata2), 32'h00);
        tick();
        w = 1'b0;
        #1;
        chk("stored_rdata1", 32'(Rdata1), 32'hA5);
        chk("wr_err_nonbusy5", 32'(wr_err), 32'd1);
        w = 1'b1; Waddr = 5'd0; Wdata = 8'hFF; Raddr2 = 5'd0;
        #1;
        chk("bypass_addr0", 32'(Rdata2), 32'h00);
        tick();
        w = 1'b0;
        #1;
        chk("wr_err_addr0", 32'(wr_err), 32'd0);

        // RAW
        Raddr1 = 5'd0; Raddr2 = 5'd0;
        issue_valid = 1'b1; issue_dst = 5'd3;
        #1;
        chk("raw_issue3_stall", 32'(stall), 32'd0);
        tick();
        chk("raw_count1", 32'(busy_count), 32'd1);
        Raddr1 = 5'd3; issue_dst = 5'd4;
        #1;
        chk("raw_stall", 32'(stall), 32'd1);
        w = 1'b1; Waddr = 5'd3; Wdata = 8'h33;
        #1;
        chk("raw_resolved_stall", 32'(stall), 32'd0);
        tick();
        w = 1'b0;
        #1;
        chk("raw_count_net", 32'(busy_count), 32'd1);
        chk("raw_wr_err", 32'(wr_err), 32'd0);

        // issue_use2 gates the Raddr2 check (reg 4 busy)
        Raddr1 = 5'd0; Raddr2 = 5'd4; issue_dst = 5'd6; issue_use2 = 1'b1;
        #1;
        chk("use2_stall", 32'(stall), 32'd1);
        issue_use2 = 1'b0;
        #1;
        chk("nouse2_stall", 32'(stall), 32'd0);
        tick();
        chk("use2_count2", 32'(busy_count), 32'd2);

        // WAW and simultaneous write/issue to same register
        Raddr2 = 5'd0; issue_dst = 5'd7;
        tick();
        chk("waw_count3", 32'(busy_count), 32'd3);
        #1;
        chk("waw_stall", 32'(stall), 32'd1);
        w = 1'b1; Waddr = 5'd7; Wdata = 8'h77;
        #1;
        chk("waw_resolved_stall", 32'(stall), 32'd0);
        tick();
        w = 1'b0;
        #1;
        chk("waw_count_same", 32'(busy_count), 32'd3);
        chk("waw_wr_err", 32'(wr_err), 32'd0);
        chk("waw_still_busy", 32'(stall), 32'd1);
        issue_valid = 1'b0;
        Raddr1 = 5'd7;
        #1;
        chk("waw_data", 32'(Rdata1), 32'h77);

        // wr_err on non-busy register
        w = 1'b1; Waddr = 5'd9; Wdata = 8'h99;
        tick();
        w = 1'b0; Raddr1 = 5'd9;
        #1;
        chk("wr_err_pulse", 32'(wr_err), 32'd1);
        chk("wr_err_data", 32'(Rdata1), 32'h99);
        tick();
        chk("wr_err_one_cycle", 32'(wr_err), 32'd0);

        // Reach busy_count=4 then reset mid-RUN
        issue_valid = 1'b1; issue_dst = 5'd10; Raddr1 = 5'd0;
        tick();
        issue_valid = 1'b0;
        chk("pre_reset_count4", 32'(busy_count), 32'd4);
        reset = 1'b1;
        tick();
        chk("midrun_rst_count", 32'(busy_count), 32'd0);
        chk("midrun_rst_ready", 32'(ready), 32'd0);
        chk("midrun_rst_stall", 32'(stall), 32'd1);
        reset = 1'b0;

        // Writes and issues are ignored during CLEAR
        w = 1'b1; Waddr = 5'd2; Wdata = 8'h22;
        issue_valid = 1'b1; issue_dst = 5'd11; Raddr1 = 5'd2;
        for (int i = 0; i < 10; i++) tick();
        chk("clear_rdata_zero", 32'(Rdata1), 32'd0);
        chk("clear_count_zero", 32'(busy_count), 32'd0);
        chk("clear_wr_err_zero", 32'(wr_err), 32'd0);
        idle_inputs();

        // Reset 10 cycles into CLEAR restarts the full sweep
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check_clear_run("clear2");
        Raddr1 = 5'd5; Raddr2 = 5'd9;
        #1;
        chk("reclear_r5", 32'(Rdata1), 32'd0);
        chk("reclear_r9", 32'(Rdata2), 32'd0);
        chk("reclear_count", 32'(busy_count), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
